rx_frame_decoder: RTL and testbench
===================================

Name: rx_frame_decoder

Overview:
- Receive-side counterpart of the transmit FIFO path, running entirely in the rxusrclk domain.
- Takes the 16-bit word stream recovered by the GT receiver and hunts for the periodic frame sync word.
- Acquires and holds frame lock with flywheel tolerance, then extracts payload words into a small show-ahead output buffer.
- The buffer offers a valid/ready interface to fabric logic, with start-of-frame tagging, overflow signalling and a sync-error counter.

Parameters:
- DATA_WIDTH, 16: rx word and payload width.
- SYNC_WORD, 16'hBC3C: frame sync pattern; occupies slot 0 of every frame.
- PAYLOAD_LEN, 8: payload words per frame (slots 1..PAYLOAD_LEN); frame length is PAYLOAD_LEN+1 words.
- LOCK_CNT, 4: consecutive correctly spaced syncs required to lock.
- UNLOCK_CNT, 2: consecutive missing syncs while locked that force loss of lock.
- FIFO_DEPTH, 4: output buffer depth (power of two).

Ports:
- rxusrclk, input, 1: receive user clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- rx_data, input, DATA_WIDTH: received word.
- rx_valid, input, 1: rx_data valid this cycle.
- dataout_ready, input, 1: downstream accepts dataout this cycle.
- dataout, output, DATA_WIDTH: head-of-buffer payload word.
- dataout_valid, output, 1: buffer non-empty.
- dataout_sof, output, 1: dataout is slot-1 (first payload) word of a frame.
- locked, output, 1: frame lock held.
- overflow, output, 1: one-cycle pulse when a payload word is dropped.
- sync_err_cnt, output, 8: saturating count of missed syncs while locked.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State HUNT; slot counter, good/bad counters and buffer pointers cleared.
  - All outputs 0.
  - Reset takes effect immediately, mid-frame included; buffer contents are discarded.
- Only cycles with rx_valid=1 are "word cycles". State, slot counter and pushes advance only on word cycles; rx_valid=0 cycles are ignored entirely.
- Slot counter runs 0..PAYLOAD_LEN and wraps to 0 after PAYLOAD_LEN. Slot 0 is the expected sync position.
- HUNT:
  - Word == SYNC_WORD: go to VERIFY, good=1, next slot=1.
  - Any other word: stay in HUNT.
- VERIFY:
  - Payload slots are discarded.
  - At slot 0, match: good+1. If good reaches LOCK_CNT, go to LOCKED with bad=0.
  - At slot 0, mismatch: go to HUNT with good=0. The mismatching word is not re-examined as a new sync.
- LOCKED:
  - Every payload-slot word is pushed into the buffer; slot 1 is pushed with sof=1, other slots with sof=0.
  - At slot 0, match: bad=0.
  - At slot 0, mismatch: bad+1 and sync_err_cnt+1 (saturates at 255).
    - If bad reaches UNLOCK_CNT, go to HUNT.
    - Otherwise stay LOCKED (flywheel) and keep pushing that frame's payload.
- locked output: registered. Rises the cycle after the word cycle carrying the LOCK_CNT-th sync. Falls the cycle after the UNLOCK_CNT-th consecutive missed sync. The payload of the frame whose sync completed lock is the first delivered.
- Buffer:
  - Synchronous FIFO of FIFO_DEPTH entries, each {sof, data}, show-ahead.
  - dataout, dataout_sof and dataout_valid are registered.
  - Latency 1: a word pushed at edge N is visible at dataout after edge N when the buffer was empty.
  - Pop occurs when dataout_valid && dataout_ready.
- Buffer boundaries:
  - Push while full with no pop in the same cycle: word dropped, overflow=1 for exactly that cycle, pointers unchanged.
  - Push and pop together while full: both succeed, no overflow.
  - Pop while empty: no effect.
  - Leaving LOCKED: buffered words remain and drain normally; no further pushes occur.
- sync_err_cnt clears only on reset.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with rx_valid toggling. Required: dataout_valid, locked, overflow and sync_err_cnt all 0; no pushes.
- Lock acquisition: rx_valid=1 continuously with 4 frames of {BC3C, 0x0001..0x0008}, dataout_ready=1. Required: locked rises the cycle after the 4th BC3C; the first delivered word is 0x0001 with dataout_sof=1; then 0x0002..0x0008 in order with sof=0.
- False sync: BC3C, then 8 words, then 0x1234 at slot 0. Required: return to HUNT; locked stays 0; dataout_valid stays 0.
- Flywheel and loss: while locked, corrupt one sync. Required: locked stays 1, sync_err_cnt=1, that frame's payload is still delivered. Corrupt two consecutive syncs. Required: locked falls after the second, sync_err_cnt=3, no further pushes.
- Backpressure/overflow: locked, dataout_ready=0. Required: 4 words buffered; the 5th word pulses overflow for one cycle; after ready goes high, exactly 0x0001..0x0004 drain in order.
- rx_valid gaps and mid-frame reset: insert rx_valid=0 gaps inside a frame. Required: slot alignment and output identical to the gapless case. Assert rst_n mid-frame while the buffer holds 2 words. Required: buffer is empty and locked=0 immediately.

Source files
------------

// File: rtl/rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_decoder
// Description : Receive-side frame decoder. Hunts for the periodic sync word,
//               acquires and holds frame lock with flywheel tolerance, and
//               delivers payload words through a show-ahead valid/ready buffer
//               with start-of-frame tagging and overflow signalling.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_decoder #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 16'hBC3C,
  parameter int                    PAYLOAD_LEN = 8,
  parameter int                    LOCK_CNT    = 4,
  parameter int                    UNLOCK_CNT  = 2,
  parameter int                    FIFO_DEPTH  = 4
) (
  input  logic                  rxusrclk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  dataout_ready,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  dataout_valid,
  output logic                  dataout_sof,
  output logic                  locked,
  output logic                  overflow,
  output logic [7:0]            sync_err_cnt
);

  localparam int SLOT_W  = $clog2(PAYLOAD_LEN + 1);
  localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [GOOD_W-1:0]   good_q;
  logic [BAD_W-1:0]    bad_q;
  logic                locked_q;
  logic [7:0]          err_q;

  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q;
  logic [PTR_W-1:0]    rd_q;
  logic [ENTRY_W-1:0]  head_q;
  logic                valid_q;
  logic                overflow_q;

  logic [SLOT_W-1:0]   slot_inc;
  logic [GOOD_W-1:0]   good_inc;
  logic [BAD_W-1:0]    bad_inc;
  logic                sync_hit;
  logic                push;
  logic [ENTRY_W-1:0]  push_entry;
  logic                full;
  logic                pop;
  logic                wr_en;
  logic [PTR_W-1:0]    wr_d;
  logic [PTR_W-1:0]    rd_d;
  logic [ENTRY_W-1:0]  head_d;
  logic                valid_d;

  assign slot_inc   = (slot_q == SLOT_W'(PAYLOAD_LEN)) ? '0 : slot_q + SLOT_W'(1);
  assign good_inc   = good_q + GOOD_W'(1);
  assign bad_inc    = bad_q + BAD_W'(1);
  assign sync_hit   = (rx_data == SYNC_WORD);
  // Every payload slot of a locked frame is delivered, including flywheel frames.
  assign push       = rx_valid && (state_q == ST_LOCKED) && (slot_q != '0);
  assign push_entry = {(slot_q == SLOT_W'(1)), rx_data};

  // Frame-alignment FSM: advances only on word cycles.
  always_ff @(posedge rxusrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      slot_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
    end else if (rx_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            state_q <= ST_VERIFY;
            good_q  <= GOOD_W'(1);
            slot_q  <= SLOT_W'(1);
          end
        end
        ST_VERIFY: begin
          if (slot_q != '0) begin
            slot_q <= slot_inc;
          end else if (sync_hit) begin
            good_q <= good_inc;
            slot_q <= slot_inc;
            if (good_inc == GOOD_W'(LOCK_CNT)) begin
              state_q  <= ST_LOCKED;
              bad_q    <= '0;
              locked_q <= 1'b1;
            end
          end else begin
            // The failing word is consumed here, not re-tested as a fresh sync.
            state_q <= ST_HUNT;
            good_q  <= '0;
            slot_q  <= '0;
          end
        end
        ST_LOCKED: begin
          if (slot_q != '0) begin
            slot_q <= slot_inc;
          end else if (sync_hit) begin
            bad_q  <= '0;
            slot_q <= slot_inc;
          end else begin
            if (err_q != 8'hFF) begin
              err_q <= err_q + 8'd1;
            end
            if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
              state_q  <= ST_HUNT;
              bad_q    <= '0;
              good_q   <= '0;
              slot_q   <= '0;
              locked_q <= 1'b0;
            end else begin
              bad_q  <= bad_inc;
              slot_q <= slot_inc;
            end
          end
        end
        default: begin
          state_q <= ST_HUNT;
          slot_q  <= '0;
        end
      endcase
    end
  end

  // Buffer pointer update and next head-of-buffer selection.
  always_comb begin
    full   = (wr_q[ADDR_W] != rd_q[ADDR_W]) &&
             (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]);
    pop    = valid_q && dataout_ready;
    wr_en  = push && (!full || pop);
    wr_d   = wr_en ? wr_q + PTR_W'(1) : wr_q;
    rd_d   = pop ? rd_q + PTR_W'(1) : rd_q;
    // If the new head slot is the one being written now, bypass the storage.
    head_d = (wr_en && (rd_d == wr_q)) ? push_entry : mem_q[rd_d[ADDR_W-1:0]];
    valid_d = (wr_d != rd_d);
  end

  // Buffer storage write; contents need no reset since valid gates them.
  always_ff @(posedge rxusrclk) begin
    if (wr_en) begin
      mem_q[wr_q[ADDR_W-1:0]] <= push_entry;
    end
  end

  // Buffer pointers and registered show-ahead outputs.
  always_ff @(posedge rxusrclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      overflow_q <= push && full && !pop;
    end
  end

  assign dataout       = head_q[DATA_WIDTH-1:0];
  assign dataout_sof   = head_q[DATA_WIDTH] && valid_q;
  assign dataout_valid = valid_q;
  assign locked        = locked_q;
  assign overflow      = overflow_q;
  assign sync_err_cnt  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_decoder
// Description : Directed self-checking bench for rx_frame_decoder: reset,
//               lock acquisition, false sync, flywheel/loss, overflow,
//               rx_valid gaps and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_decoder;

  localparam logic [15:0] SYNC = 16'hBC3C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        dataout_ready;
  logic [15:0] dataout;
  logic        dataout_valid;
  logic        dataout_sof;
  logic        locked;
  logic        overflow;
  logic [7:0]  sync_err_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int ovf_cnt = 0;
  logic [16:0] got [$];

  rx_frame_decoder dut (
    .rxusrclk      (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .dataout_ready (dataout_ready),
    .dataout       (dataout),
    .dataout_valid (dataout_valid),
    .dataout_sof   (dataout_sof),
    .locked        (locked),
    .overflow      (overflow),
    .sync_err_cnt  (sync_err_cnt)
  );

  always #5 clk = ~clk;

  // Record every accepted word and every overflow pulse, mid-cycle.
  always @(negedge clk) begin
    if (dataout_valid && dataout_ready) got.push_back({dataout_sof, dataout});
    if (overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 17'h1FFFF;
  endfunction

  // Expect got[off..off+7] to be the payload 1..8 with sof on the first word.
  task automatic check_frame(input string tag, input int off, input int exp_size);
    logic [16:0] e;
    check({tag, "_size"}, got.size(), exp_size);
    for (int k = 1; k <= 8; k++) begin
      e = {(k == 1), 16'(k)};
      check($sformatf("%s_w%0d", tag, k), got_at(off + k - 1), e);
    end
  endtask

  task automatic send(input logic [15:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_payload();
    for (int k = 1; k <= 8; k++) send(16'(k));
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = SYNC;
    dataout_ready = 1'b0;

    // Reset held with rx_valid toggling.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rx_valid = ~rx_valid;
    end
    check("rst_valid", dataout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", sync_err_cnt, 0);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    dataout_ready = 1'b1;
    idle();

    // Lock acquisition over four frames.
    got.delete();
    for (int i = 0; i < 4; i++) begin
      send(SYNC);
      check($sformatf("acq_locked%0d", i), locked, (i == 3));
      send_payload();
    end
    send(16'h0000);              // first corrupted sync, flywheel
    check_frame("acq", 0, 8);
    check("fly_locked", locked, 1);
    check("fly_err", sync_err_cnt, 1);
    got.delete();
    send_payload();
    send(SYNC);
    check_frame("fly", 0, 8);

    // Two consecutive misses lose lock.
    got.delete();
    send_payload();
    send(16'h0000);
    check("loss1_locked", locked, 1);
    check("loss1_err", sync_err_cnt, 2);
    send_payload();
    send(16'h0000);
    check("loss2_locked", locked, 0);
    check("loss2_err", sync_err_cnt, 3);
    send_payload();
    check("loss_count", got.size(), 16);
    check("loss_second_sof", got_at(8), {1'b1, 16'h0001});
    check("loss_valid", dataout_valid, 0);

    // False sync returns to hunt.
    send(SYNC);
    send_payload();
    send(16'h1234);
    check("false_locked", locked, 0);
    check("false_valid", dataout_valid, 0);

    // Re-acquire lock, then backpressure into overflow.
    for (int i = 0; i < 4; i++) begin
      send(SYNC);
      check($sformatf("reacq_locked%0d", i), locked, (i == 3));
      if (i < 3) send_payload();
    end
    dataout_ready = 1'b0;
    got.delete();
    ovf_cnt = 0;
    send(16'h0001);
    check("bp_valid", dataout_valid, 1);
    check("bp_data", dataout, 16'h0001);
    check("bp_sof", dataout_sof, 1);
    send(16'h0002);
    send(16'h0003);
    send(16'h0004);
    check("bp_full_ovf", overflow, 0);
    check("bp_head", dataout, 16'h0001);
    send(16'h0005);
    check("bp_ovf_pulse", overflow, 1);
    idle();
    check("bp_ovf_clear", overflow, 0);
    dataout_ready = 1'b1;
    repeat (6) idle();
    check("bp_drain_n", got.size(), 4);
    for (int k = 1; k <= 4; k++)
      check($sformatf("bp_drain%0d", k), got_at(k - 1), {(k == 1), 16'(k)});
    check("bp_ovf_cnt", ovf_cnt, 1);
    check("bp_empty", dataout_valid, 0);
    send(16'h0006);
    send(16'h0007);
    send(16'h0008);
    send(SYNC);
    check("bp_realign_locked", locked, 1);

    // rx_valid gaps inside a frame.
    got.delete();
    for (int k = 1; k <= 8; k++) begin
      if (k % 2 == 1) idle();
      send(16'(k));
    end
    idle();
    send(SYNC);
    idle();
    check_frame("gap", 0, 8);
    check("gap_locked", locked, 1);
    check("gap_err", sync_err_cnt, 3);

    // Mid-frame reset with two words buffered.
    dataout_ready = 1'b0;
    send(16'h0001);
    send(16'h0002);
    check("mid_valid", dataout_valid, 1);
    check("mid_data", dataout, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", dataout_valid, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_err", sync_err_cnt, 0);
    check("mid_rst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    check("post_rst_valid", dataout_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
